instr_fetch_unit: RTL

Instruction fetch stage sitting directly downstream of the program counter register. It takes the registered PC value, issues one instruction-memory read per PC over a request/grant/response handshake, and presents the returned instruction with its PC to decode under a valid/ready handshake. On each accepted instruction it pulses `pc_advance`, the write enable of the PC register. It also supports a control-flow flush that discards in-flight fetches.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 44 ++++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the instruction substituted for a misaligned PC, and the alignment width.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // addi x0, x0, 0 -- presented in place of a fetch from a misaligned PC
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Instruction words are 4-byte aligned
  localparam int WORD_ALIGN_BITS = 2;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch stage: the instruction-memory read port and the
// instruction port towards decode.
//
// Handshakes:
//   imem: imem_req/imem_addr are held stable until imem_gnt is seen high in
//         the same cycle as imem_req; exactly one imem_rvalid pulse answers
//         each grant, and at most one read is outstanding at any time.
//   decode: instr/instr_pc/instr_misaligned are valid while instr_valid is
//         high and stay stable until a cycle with instr_valid & instr_ready,
//         which is the single transfer cycle.
interface instr_fetch_unit_if #(
  parameter int WIDTH = 32,
  parameter int ILEN  = 32
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [ILEN-1:0]  imem_rdata;

  logic             instr_valid;
  logic             instr_ready;
  logic [ILEN-1:0]  instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_misaligned;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc, instr_misaligned,
    input  instr_ready
  );

  // Memory / decode side
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc, instr_misaligned,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one memory read per PC, instruction buffered
// for decode, PC register advanced on each accepted instruction, and a
// flush that discards in-flight work (draining an orphaned read if needed).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ILEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  input  logic [WIDTH-1:0] pc,
  input  logic             flush,
  output logic             pc_advance,
  output logic [31:0]      fetch_count,
  output state_t           dbg_state,
  instr_fetch_unit_if.master bus
);

  state_t           state_q;
  logic [WIDTH-1:0] cur_pc_q;
  logic             pc_lat_q;
  logic [ILEN-1:0]  instr_q;
  logic [WIDTH-1:0] instr_pc_q;
  logic             instr_valid_q;
  logic             misaligned_q;
  logic [31:0]      fetch_count_q;

  logic [WIDTH-1:0] cur_pc;
  logic             aligned;
  state_t           next_start;

  // In the first REQ cycle the PC is taken straight from the PC register,
  // so an advance at the end of HOLD is seen by the very next request;
  // from then on the latched copy keeps the address stable until grant.
  assign cur_pc  = pc_lat_q ? cur_pc_q : pc;
  assign aligned = (cur_pc[WORD_ALIGN_BITS-1:0] == '0);

  assign bus.imem_req  = (state_q == REQ) && aligned;
  assign bus.imem_addr = bus.imem_req
                         ? {cur_pc[WIDTH-1:WORD_ALIGN_BITS], {WORD_ALIGN_BITS{1'b0}}}
                         : '0;

  assign pc_advance = (state_q == HOLD) && bus.instr_ready && !flush;

  assign next_start = fetch_en ? REQ : IDLE;

  assign bus.instr_valid      = instr_valid_q;
  assign bus.instr            = instr_q;
  assign bus.instr_pc         = instr_pc_q;
  assign bus.instr_misaligned = misaligned_q;
  assign fetch_count          = fetch_count_q;
  assign dbg_state            = state_q;

  // Fetch FSM with its registered outputs and the accepted-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_pc_q      <= '0;
      pc_lat_q      <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en) begin
            state_q <= REQ;
          end
        end

        REQ: begin
          if (flush) begin
            // A request granted in this cycle still owes us a response
            state_q  <= (bus.imem_req && bus.imem_gnt) ? DRAIN : next_start;
            pc_lat_q <= 1'b0;
          end else if (!aligned) begin
            instr_q       <= ILEN'(NOP_INSTR);
            instr_pc_q    <= cur_pc;
            misaligned_q  <= 1'b1;
            instr_valid_q <= 1'b1;
            pc_lat_q      <= 1'b0;
            state_q       <= HOLD;
          end else begin
            cur_pc_q <= cur_pc;
            pc_lat_q <= !bus.imem_gnt;
            if (bus.imem_gnt) begin
              state_q <= WAIT;
            end
          end
        end

        WAIT: begin
          if (flush) begin
            // A response arriving together with the flush is already
            // consumed, so there is nothing left to drain.
            state_q <= bus.imem_rvalid ? next_start : DRAIN;
          end else if (bus.imem_rvalid) begin
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= cur_pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end

        HOLD: begin
          if (flush) begin
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            state_q       <= next_start;
          end else if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= fetch_count_q + 32'd1;
            state_q       <= next_start;
          end
        end

        DRAIN: begin
          // A flush here changes nothing: the orphaned read must still be
          // absorbed before a new request may be issued.
          if (bus.imem_rvalid) begin
            state_q <= next_start;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
